// File: rtl/bcd_serializer_pkg.sv
// Shared BCD constants (ASCII codes, state encoding) and helpers for the BCD
// serializer and future display drivers.
`ifndef BCD_VH
`define BCD_VH
`define BCD_ASCII_ZERO    8'h30
`define BCD_ASCII_INVALID 8'h3F
`define BCD_STATE_IDLE    1'b0
`define BCD_STATE_SEND    1'b1
`endif

package bcd_serializer_pkg;

  typedef enum logic {
    ST_IDLE = `BCD_STATE_IDLE,
    ST_SEND = `BCD_STATE_SEND
  } state_t;

  // Non-decimal nibbles are shown as '?' so corrupted input is visible on a console.
  function automatic logic [7:0] digit_to_ascii(input logic [3:0] digit);
    if (digit <= 4'd9)
      return `BCD_ASCII_ZERO + {4'h0, digit};
    else
      return `BCD_ASCII_INVALID;
  endfunction

endpackage

// File: rtl/bcd_leading_zero_counter.sv
// Counts zero digits from the most-significant end of a packed BCD word.
// Digit 0 is never counted, so an all-zero word still leaves one digit to show.
module bcd_leading_zero_counter #(
  parameter int NUMBER_DIGITS = 3,
  parameter int CNT_W         = $clog2(NUMBER_DIGITS + 1)
) (
  input  logic [NUMBER_DIGITS*4-1:0] bcd,
  output logic [CNT_W-1:0]           count
);

  logic still_zero;

  always_comb begin
    count      = '0;
    still_zero = 1'b1;
    for (int i = NUMBER_DIGITS - 1; i >= 1; i--) begin
      if (still_zero && (bcd[i*4 +: 4] == 4'd0))
        count = count + 1'b1;
      else
        still_zero = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serializer.sv
// Emits a packed BCD word as ASCII characters, most-significant digit first,
// one character per valid/ready handshake, with optional leading-zero suppression.
module bcd_serializer
  import bcd_serializer_pkg::*;
#(
  parameter int WIDTH_BCD              = 12,
  parameter bit SUPPRESS_LEADING_ZEROS = 1'b1
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 bcd_valid,
  output logic                 bcd_ready,
  input  logic [WIDTH_BCD-1:0] bcd,
  output logic                 char_valid,
  input  logic                 char_ready,
  output logic [7:0]           char,
  output logic                 char_last
);

  localparam int NUMBER_DIGITS = WIDTH_BCD / 4;
  localparam int CNT_W         = $clog2(NUMBER_DIGITS + 1);

  state_t               state;
  state_t               state_nxt;
  logic [WIDTH_BCD-1:0] shreg;
  logic [CNT_W-1:0]     remaining;
  logic [CNT_W-1:0]     lz_raw;
  logic [CNT_W-1:0]     lz;
  logic                 load;
  logic                 advance;
  logic                 on_last;

  bcd_leading_zero_counter #(
    .NUMBER_DIGITS (NUMBER_DIGITS),
    .CNT_W         (CNT_W)
  ) u_lzc (
    .bcd   (bcd),
    .count (lz_raw)
  );

  assign lz      = SUPPRESS_LEADING_ZEROS ? lz_raw : '0;
  assign on_last = (remaining == CNT_W'(1));

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bcd_valid) begin
          load      = 1'b1;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (char_ready) begin
          if (on_last)
            state_nxt = ST_IDLE;
          else
            advance = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Capture pre-shifts past suppressed zeros so the first digit to send is always the top nibble.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      remaining <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        shreg     <= bcd << {lz, 2'b00};
        remaining <= CNT_W'(NUMBER_DIGITS) - lz;
      end else if (advance) begin
        shreg     <= shreg << 4;
        remaining <= remaining - 1'b1;
      end
    end
  end

  // Outputs decode registered state only, so nothing combinational reaches them from the handshakes.
  assign bcd_ready  = (state == ST_IDLE);
  assign char_valid = (state == ST_SEND);
  assign char       = char_valid ? digit_to_ascii(shreg[WIDTH_BCD-1 -: 4]) : 8'h00;
  assign char_last  = char_valid && on_last;

endmodule

// File: tb/tb_bcd_serializer.sv
// Bench for bcd_serializer: three instances (3 digits suppressing, 3 digits not
// suppressing, 1 digit) checked every cycle against a queue-style character model.
module tb_bcd_serializer;

  logic        clock = 1'b0;
  logic        resetn;
  logic        bcd_valid;
  logic        char_ready;
  logic [11:0] bcd;

  logic       rdy [3];
  logic       cv  [3];
  logic       cl  [3];
  logic [7:0] ch  [3];

  int tests = 0;
  int fails = 0;

  logic [7:0] mc   [3][3];
  logic       ml   [3][3];
  int         mlen [3];
  int         mpos [3];
  bit         armed = 1'b0;

  logic [8:0] log0 [$];
  logic [8:0] log1 [$];
  logic [8:0] exp_buf [5];

  always #5 clock = ~clock;

  bcd_serializer #(.WIDTH_BCD(12), .SUPPRESS_LEADING_ZEROS(1'b1)) dut_s (
    .clock(clock), .resetn(resetn), .bcd_valid(bcd_valid), .bcd_ready(rdy[0]),
    .bcd(bcd), .char_valid(cv[0]), .char_ready(char_ready), .char(ch[0]), .char_last(cl[0]));

  bcd_serializer #(.WIDTH_BCD(12), .SUPPRESS_LEADING_ZEROS(1'b0)) dut_n (
    .clock(clock), .resetn(resetn), .bcd_valid(bcd_valid), .bcd_ready(rdy[1]),
    .bcd(bcd), .char_valid(cv[1]), .char_ready(char_ready), .char(ch[1]), .char_last(cl[1]));

  bcd_serializer #(.WIDTH_BCD(4), .SUPPRESS_LEADING_ZEROS(1'b1)) dut_1 (
    .clock(clock), .resetn(resetn), .bcd_valid(bcd_valid), .bcd_ready(rdy[2]),
    .bcd(bcd[3:0]), .char_valid(cv[2]), .char_ready(char_ready), .char(ch[2]), .char_last(cl[2]));

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected character list for a word: digits MSB first, optionally starting at the first non-zero digit.
  task automatic model_load(input int k, input logic [11:0] v);
    int         n;
    int         first;
    logic [3:0] d;
    n     = (k == 2) ? 1 : 3;
    first = n - 1;
    if (k != 1)
      while (first > 0 && ((v >> (4 * first)) & 12'hF) == 12'h0) first--;
    mlen[k] = 0;
    mpos[k] = 0;
    for (int i = first; i >= 0; i--) begin
      d = v[4*i +: 4];
      mc[k][mlen[k]] = (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
      ml[k][mlen[k]] = (i == 0);
      mlen[k]++;
    end
  endtask

  always @(negedge clock) begin
    bit busy;
    for (int k = 0; k < 3; k++) begin
      busy = (mpos[k] < mlen[k]);
      if (armed) begin
        check($sformatf("inst%0d char_valid", k), {8'h0, cv[k]},  {8'h0, busy});
        check($sformatf("inst%0d bcd_ready", k),  {8'h0, rdy[k]}, {8'h0, !busy});
        check($sformatf("inst%0d char", k),       {1'b0, ch[k]},  busy ? {1'b0, mc[k][mpos[k]]} : 9'h000);
        check($sformatf("inst%0d char_last", k),  {8'h0, cl[k]},  {8'h0, busy && ml[k][mpos[k]]});
        if (k == 0 && cv[0] && char_ready) log0.push_back({cl[0], ch[0]});
        if (k == 1 && cv[1] && char_ready) log1.push_back({cl[1], ch[1]});
      end
      if (!resetn) begin
        mlen[k] = 0;
        mpos[k] = 0;
      end else if (busy && char_ready) begin
        mpos[k]++;
      end else if (!busy && bcd_valid) begin
        model_load(k, bcd);
      end
    end
    if (!resetn) armed = 1'b1;
  end

  // Present a word until instance 0 takes it; returns at posedge+1 of the accept edge.
  task automatic present(input logic [11:0] v, input bit rnd);
    bit ok;
    ok        = 1'b0;
    bcd       = v;
    bcd_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clock);
      if (rdy[0]) begin
        ok = 1'b1;
        break;
      end
      @(posedge clock);
      #1;
      if (rnd) char_ready = 1'($urandom_range(0, 1));
    end
    @(posedge clock);
    #1;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL accept timeout: word %h not accepted", v);
    end
  endtask

  task automatic wait_count(input int n, input bit rnd);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (log0.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(posedge clock);
      #1;
      if (rnd) char_ready = 1'($urandom_range(0, 1));
    end
    char_ready = 1'b1;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL char timeout: got %0d chars, expected %0d", log0.size(), n);
    end
  endtask

  task automatic idle(input int n);
    bcd_valid = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect_log(input string name, input int which, input int n);
    int sz;
    sz = (which == 0) ? log0.size() : log1.size();
    check({name, " count"}, 9'(sz), 9'(n));
    for (int i = 0; i < n && i < sz; i++)
      check($sformatf("%s char%0d", name, i), (which == 0) ? log0[i] : log1[i], exp_buf[i]);
    log0.delete();
    log1.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] w;
    resetn     = 1'b0;
    bcd_valid  = 1'b0;
    char_ready = 1'b1;
    bcd        = '0;

    // Pin the model against hand-computed values.
    model_load(0, 12'h1A5);
    check("model 1A5 len", 9'(mlen[0]), 9'd3);
    check("model 1A5 mid", {1'b0, mc[0][1]}, 9'h03F);
    model_load(0, 12'h007);
    check("model 007", {ml[0][0], mc[0][0]} | 9'(mlen[0] << 12), 9'h137);
    model_load(1, 12'h000);
    check("model nosup 000 len", 9'(mlen[1]), 9'd3);
    model_load(2, 12'h000);
    check("model n1 zero", {ml[2][0], mc[2][0]}, 9'h130);
    for (int k = 0; k < 3; k++) begin
      mlen[k] = 0;
      mpos[k] = 0;
    end

    repeat (3) @(posedge clock);
    #1;
    resetn = 1'b1;
    @(negedge clock);
    check("reset bcd_ready", {8'h0, rdy[0]}, 9'h001);
    check("reset char_valid", {8'h0, cv[0]}, 9'h000);
    check("reset char", {1'b0, ch[0]}, 9'h000);
    check("reset char_last", {8'h0, cl[0]}, 9'h000);
    @(posedge clock);
    #1;

    log0.delete();
    present(12'h123, 1'b0); bcd_valid = 1'b0; wait_count(3, 1'b0);
    exp_buf = '{9'h031, 9'h032, 9'h133, 9'h000, 9'h000};
    expect_log("word 123", 0, 3);

    idle(6);
    present(12'h007, 1'b0); bcd_valid = 1'b0; wait_count(1, 1'b0);
    exp_buf = '{9'h137, 9'h000, 9'h000, 9'h000, 9'h000};
    expect_log("word 007", 0, 1);

    idle(6);
    present(12'h000, 1'b0); bcd_valid = 1'b0; wait_count(1, 1'b0);
    idle(6);
    exp_buf = '{9'h130, 9'h000, 9'h000, 9'h000, 9'h000};
    expect_log("word 000", 0, 1);

    idle(6);
    present(12'h000, 1'b0); bcd_valid = 1'b0;
    idle(6);
    exp_buf = '{9'h030, 9'h030, 9'h130, 9'h000, 9'h000};
    expect_log("nosup 000", 1, 3);

    idle(6);
    present(12'h456, 1'b0); bcd_valid = 1'b0; wait_count(3, 1'b1);
    exp_buf = '{9'h034, 9'h035, 9'h136, 9'h000, 9'h000};
    expect_log("stalled 456", 0, 3);

    idle(6);
    present(12'h1A5, 1'b0); bcd_valid = 1'b0; wait_count(3, 1'b0);
    exp_buf = '{9'h031, 9'h03F, 9'h135, 9'h000, 9'h000};
    expect_log("word 1A5", 0, 3);

    idle(6);
    present(12'h987, 1'b0); bcd_valid = 1'b0; wait_count(1, 1'b0);
    char_ready = 1'b0;
    resetn     = 1'b0;
    @(posedge clock);
    #1;
    resetn     = 1'b1;
    char_ready = 1'b1;
    @(negedge clock);
    check("abort char_valid", {8'h0, cv[0]}, 9'h000);
    check("abort bcd_ready", {8'h0, rdy[0]}, 9'h001);
    @(posedge clock);
    #1;
    exp_buf = '{9'h039, 9'h000, 9'h000, 9'h000, 9'h000};
    expect_log("aborted 987", 0, 1);
    present(12'h045, 1'b0); bcd_valid = 1'b0; wait_count(2, 1'b0);
    exp_buf = '{9'h034, 9'h135, 9'h000, 9'h000, 9'h000};
    expect_log("word 045", 0, 2);

    idle(6);
    present(12'h012, 1'b0);
    present(12'h300, 1'b0);
    bcd_valid = 1'b0;
    wait_count(5, 1'b0);
    exp_buf = '{9'h031, 9'h132, 9'h033, 9'h030, 9'h130};
    expect_log("back to back", 0, 5);

    for (int n = 0; n < 40; n++) begin
      for (int d = 0; d < 3; d++)
        w[4*d +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                    : (($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 9)));
      present(w, 1'b1);
      if ($urandom_range(0, 1) == 0) begin
        bcd_valid = 1'b0;
        repeat ($urandom_range(0, 3)) begin
          @(posedge clock);
          #1;
          char_ready = 1'($urandom_range(0, 1));
        end
      end
    end
    char_ready = 1'b1;
    idle(10);
    log0.delete();
    log1.delete();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
